// File: rtl/shift_step_sequencer.sv
// Sequences a 64-bit load/enable shift register through greedy 8-steps then 1-steps.
// Optional SHIFT_STEP_SEQUENCER_ABORT_EN adds an abort input that cancels an in-flight request.
module shift_step_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              dir,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              sh_load,
  output logic              sh_ena,
  output logic [1:0]        sh_amount,
  output logic [DATA_W-1:0] sh_data,
  input  logic [DATA_W-1:0] sh_q,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   rem_dec;
  logic               op_dir;
  logic               abort_hit;

  always_comb rem_dec = (rem >= CNT_W'(8)) ? rem - CNT_W'(8) : rem - CNT_W'(1);

`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
  assign abort_hit = abort && (state == LOAD || state == SHIFT || state == CAPTURE);
`else
  assign abort_hit = 1'b0;
`endif

  // Outputs are registered with the state they belong to, so each is computed
  // from the next-state values rather than decoded after the fact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rem          <= '0;
      op_dir       <= 1'b0;
      ready        <= 1'b1;
      sh_load      <= 1'b0;
      sh_ena       <= 1'b0;
      sh_amount    <= 2'b00;
      sh_data      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      sh_load      <= 1'b0;
      sh_ena       <= 1'b0;
      sh_amount    <= 2'b00;
      sh_data      <= '0;
      result_valid <= 1'b0;
      if (abort_hit) begin
        state <= IDLE;
        rem   <= '0;
        ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_dir  <= dir;
              rem     <= count;
              state   <= LOAD;
              ready   <= 1'b0;
              sh_load <= 1'b1;
              sh_data <= data;
            end
          end
          LOAD: begin
            if (rem != '0) begin
              state     <= SHIFT;
              sh_ena    <= 1'b1;
              sh_amount <= {op_dir, rem >= CNT_W'(8)};
            end else begin
              state <= CAPTURE;
            end
          end
          SHIFT: begin
            rem <= rem_dec;
            if (rem_dec == '0) begin
              state <= CAPTURE;
            end else begin
              sh_ena    <= 1'b1;
              sh_amount <= {op_dir, rem_dec >= CNT_W'(8)};
            end
          end
          CAPTURE: begin
            result       <= sh_q;
            result_valid <= 1'b1;
            state        <= DONE;
          end
          DONE: begin
            state <= IDLE;
            ready <= 1'b1;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_step_sequencer.sv
// Bench for shift_step_sequencer driving a behavioural 64-bit load/enable shift register.
// Expected results go into a scoreboard queue at start and are popped on result_valid.
module tb_shift_step_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        dir;
  logic [5:0]  count;
  logic [63:0] data;
  logic        ready, sh_load, sh_ena, result_valid;
  logic [1:0]  sh_amount;
  logic [63:0] sh_data, sh_q, result;
`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
  logic        abort;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  shift_step_sequencer #(.DATA_W(64), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .start(start),
`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
    .abort(abort),
`endif
    .dir(dir), .count(count), .data(data),
    .ready(ready), .sh_load(sh_load), .sh_ena(sh_ena), .sh_amount(sh_amount),
    .sh_data(sh_data), .sh_q(sh_q), .result(result), .result_valid(result_valid)
  );

  // Downstream shift register: load wins, amount = {arith_right, by_8}.
  logic [63:0] sr = '0;
  always_ff @(posedge clk) begin
    if (sh_load) sr <= sh_data;
    else if (sh_ena) begin
      case (sh_amount)
        2'b00: sr <= sr << 1;
        2'b01: sr <= sr << 8;
        2'b10: sr <= $signed(sr) >>> 1;
        default: sr <= $signed(sr) >>> 8;
      endcase
    end
  end
  assign sh_q = sr;

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; dir = 1'b0; count = '0; data = '0;
`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    total++;
    if ({ready, sh_load, sh_ena, sh_amount, result_valid} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl got %b want 100000", {ready, sh_load, sh_ena, sh_amount, result_valid});
    end
    total++;
    if (sh_data !== 64'h0 || result !== 64'h0) begin
      bad++; $display("FAIL reset_data sh_data=%h result=%h want 0", sh_data, result);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Runs one request; poke pulses start with other operands while busy.
  task automatic run_op(input logic d, input int c, input logic [63:0] v, input bit poke);
    logic [63:0]        exp_r, exp_pop;
    logic signed [63:0] sv;
    logic [1:0]         amts[$];
    int n, lat, nsh, nld;
    sv    = v;
    exp_r = d ? 64'(sv >>> c) : (v << c);
    sb.push_back(exp_r);
    for (int i = 0; i < c / 8; i++) amts.push_back({d, 1'b1});
    for (int i = 0; i < c % 8; i++) amts.push_back({d, 1'b0});
    n = c / 8 + c % 8;
    lat = 0; nsh = 0; nld = 0;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL idle_ready got %b want 1", ready); end
    start = 1'b1; dir = d; count = 6'(c); data = v;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; dir = ~d; count = ~6'(c); data = ~v; end
      if (poke) start = (cyc == 2);
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready cyc=%0d got %b want 0", cyc, ready); end
      total++;
      if (sh_load && sh_ena) begin bad++; $display("FAIL load_ena_excl cyc=%0d both high", cyc); end
      if (sh_load) begin
        nld++;
        total++;
        if (sh_data !== v) begin bad++; $display("FAIL load_data got %h want %h", sh_data, v); end
      end else begin
        total++;
        if (sh_data !== 64'h0) begin bad++; $display("FAIL sh_data_idle cyc=%0d got %h want 0", cyc, sh_data); end
      end
      if (sh_ena) begin
        total++;
        if (nsh >= amts.size()) begin
          bad++; $display("FAIL extra_step cyc=%0d step=%0d want only %0d", cyc, nsh, n);
        end else if (sh_amount !== amts[nsh]) begin
          bad++; $display("FAIL amount step=%0d got %b want %b", nsh, sh_amount, amts[nsh]);
        end
        nsh++;
      end
      if (result_valid) lat = cyc;
    end
    start = 1'b0;
    total++;
    if (lat != n + 3) begin bad++; $display("FAIL latency count=%0d got %0d want %0d", c, lat, n + 3); end
    total++;
    if (nsh != n) begin bad++; $display("FAIL step_count got %0d want %0d", nsh, n); end
    total++;
    if (nld != 1) begin bad++; $display("FAIL load_count got %0d want 1", nld); end
    exp_pop = sb.pop_front();
    total++;
    if (result !== exp_pop) begin bad++; $display("FAIL result d=%0d c=%0d got %h want %h", d, c, result, exp_pop); end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || sh_load !== 1'b0) begin
      bad++; $display("FAIL post_done ready=%b rv=%b load=%b want 1 0 0", ready, result_valid, sh_load);
    end
    total++;
    if (result !== exp_pop) begin bad++; $display("FAIL result_hold got %h want %h", result, exp_pop); end
  endtask

  task automatic test_directed();
    run_op(1'b0, 10, 64'h1, 1'b0);
    run_op(1'b1, 9, 64'h8000_0000_0000_0000, 1'b0);
    run_op(1'b0, 63, 64'h1, 1'b0);
    run_op(1'b0, 0, 64'hDEAD_BEEF_0123_4567, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), {$urandom, $urandom}, 1'b0);
  endtask

  task automatic test_busy();
    run_op(1'b0, 10, 64'h0000_0000_0000_00F3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (ready !== 1'b1 || sh_load !== 1'b0 || result_valid !== 1'b0) begin
        bad++; $display("FAIL busy_ignored ready=%b load=%b rv=%b want 1 0 0", ready, sh_load, result_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    start = 1'b1; dir = 1'b1; count = 6'd20; data = 64'hF000_0000_0000_1234;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (sh_ena !== 1'b1) begin bad++; $display("FAIL mid_in_shift sh_ena=%b want 1", sh_ena); end
    resetn = 1'b0;
    #1;
    total++;
    if ({ready, sh_load, sh_ena, sh_amount, result_valid} !== 6'b100000 || sh_data !== 64'h0 || result !== 64'h0) begin
      bad++; $display("FAIL mid_reset ctrl=%b sh_data=%h result=%h want 100000 0 0",
                      {ready, sh_load, sh_ena, sh_amount, result_valid}, sh_data, result);
    end
    @(negedge clk); resetn = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid || !ready) rv_seen++;
    end
    total++;
    if (rv_seen != 0) begin bad++; $display("FAIL mid_reset_quiet got %0d bad cycles want 0", rv_seen); end
  endtask

`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
  task automatic test_abort();
    logic [63:0] prev;
    int rv_seen;
    run_op(1'b0, 4, 64'h5, 1'b0);
    prev = result;
    start = 1'b1; dir = 1'b0; count = 6'd20; data = 64'h7;
    @(negedge clk); start = 1'b0;       // LOAD
    @(negedge clk);                     // 1st SHIFT
    @(negedge clk);                     // 2nd SHIFT
    total++;
    if (sh_ena !== 1'b1) begin bad++; $display("FAIL abort_pre sh_ena=%b want 1", sh_ena); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++;
    if (ready !== 1'b1 || sh_ena !== 1'b0 || sh_load !== 1'b0) begin
      bad++; $display("FAIL abort_idle ready=%b ena=%b load=%b want 1 0 0", ready, sh_ena, sh_load);
    end
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    total++;
    if (rv_seen != 0 || result !== prev) begin
      bad++; $display("FAIL abort_result rv=%0d result=%h want 0 %h", rv_seen, result, prev);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy();
    test_reset_mid();
`ifdef SHIFT_STEP_SEQUENCER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
